pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_lock_seq_pkg.sv | 31 +++
 rtl/sync_2ff.sv | 24 ++
 rtl/pll_lock_sequencer.sv | 151 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_seq_pkg.sv
// PLL lock sequencer shared types: state encoding, field widths and
// sizing helpers for the shared cycle counter.
package pll_lock_seq_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    function automatic int unsigned max3(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, reset to 0.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronised out).
module sync_2ff
    import pll_lock_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses pll_reset, waits for a stable lock,
// then releases sys_rst; retries on timeout and parks in FAIL.
// Ports: clkin (ref clock), rst (sync, active-high), lock (async PLL lock),
//   retry_req (restart from FAIL), pll_reset, sys_rst, ready, fail,
//   retry_cnt[3:0], state_o[2:0]; loss_cnt[7:0] when
//   PLL_LOCK_SEQ_LOSS_CNT_EN is defined.
module pll_lock_sequencer
    import pll_lock_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = 16,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES    = 4
) (
    input  logic               clkin,
    input  logic               rst,
    input  logic               lock,
    input  logic               retry_req,
    output logic               pll_reset,
    output logic               sys_rst,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [STATE_W-1:0] state_o
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    ,
    output logic [LOSS_W-1:0]  loss_cnt
`endif
);

    localparam int unsigned CNT_MAX =
        max3(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);
    localparam int unsigned CNT_W = cnt_width(CNT_MAX);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRIES);

    state_t             state_q;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_n;
    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_n;
    logic               lock_s;

    sync_2ff u_lock_sync (
        .clk (clkin),
        .rst (rst),
        .d   (lock),
        .q   (lock_s)
    );

    // Each counted state leaves on its last cycle, so the counter
    // never exceeds its target and never wraps.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        retry_n = retry_q;
        unique case (state_q)
            RST_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_n = STABLE;
                    cnt_n   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    retry_n = retry_q + 1'b1;
                    cnt_n   = '0;
                    state_n = (retry_n == RETRY_LIM) ? FAIL : RST_PLL;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt_q == STB_LAST) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            RUN: begin
                cnt_n = '0;
                if (!lock_s) begin
                    state_n = RST_PLL;
                end
            end
            FAIL: begin
                cnt_n = '0;
                if (retry_req) begin
                    state_n = RST_PLL;
                    retry_n = '0;
                end
            end
            default: begin
                state_n = RST_PLL;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the
    // same edge as the state register.
    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q   <= RST_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_reset <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            retry_q   <= retry_n;
            pll_reset <= (state_n == RST_PLL);
            sys_rst   <= (state_n != RUN);
            ready     <= (state_n == RUN);
            fail      <= (state_n == FAIL);
        end
    end

    assign retry_cnt = retry_q;
    assign state_o   = state_q;

`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    always_ff @(posedge clkin) begin
        if (rst) begin
            loss_cnt <= '0;
        end else if (state_q == RUN && state_n == RST_PLL
                     && loss_cnt != '1) begin
            loss_cnt <= loss_cnt + 1'b1;
        end
    end
`else
    // Lock-loss counter not built.
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with a per-cycle reference model.
// Ports of the DUT are all connected; loss_cnt only when the macro is set.
module tb_pll_lock_sequencer;

    localparam int RSTC = 4;
    localparam int STBC = 16;
    localparam int TMOC = 64;
    localparam int MAXR = 3;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_RUN  = 3;
    localparam int P_FAIL = 4;

    localparam int S_PR  = 0;
    localparam int S_SR  = 1;
    localparam int S_RDY = 2;
    localparam int S_FL  = 3;

    logic       clkin;
    logic       rst;
    logic       lock;
    logic       retry_req;
    logic       pll_reset;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [2:0] state_o;
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    int total = 0;
    int bad   = 0;

    pll_lock_sequencer #(
        .RST_CYCLES     (RSTC),
        .STABLE_CYCLES  (STBC),
        .TIMEOUT_CYCLES (TMOC),
        .MAX_RETRIES    (MAXR)
    ) dut (
        .clkin     (clkin),
        .rst       (rst),
        .lock      (lock),
        .retry_req (retry_req),
        .pll_reset (pll_reset),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .fail      (fail),
        .retry_cnt (retry_cnt),
        .state_o   (state_o)
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
        ,
        .loss_cnt  (loss_cnt)
`endif
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Reference model: phase plus time spent in it, driven by what the
    // lock line looked like two edges earlier.
    int m_phase   = P_RST;
    int m_age     = 0;
    int m_tries   = 0;
    int m_loss    = 0;
    bit m_s1      = 0;
    bit m_ls      = 0;
    bit started   = 0;

    function automatic void enter(input int p);
        m_phase = p;
        m_age   = 0;
    endfunction

    always @(posedge clkin) begin
        if (rst) begin
            enter(P_RST);
            m_tries = 0;
            m_loss  = 0;
            m_s1    = 0;
            m_ls    = 0;
            started = 1;
        end else begin
            case (m_phase)
                P_RST: begin
                    m_age++;
                    if (m_age == RSTC) enter(P_WAIT);
                end
                P_WAIT: begin
                    if (m_ls) enter(P_STAB);
                    else begin
                        m_age++;
                        if (m_age == TMOC) begin
                            m_tries++;
                            enter(m_tries == MAXR ? P_FAIL : P_RST);
                        end
                    end
                end
                P_STAB: begin
                    if (!m_ls) enter(P_WAIT);
                    else begin
                        m_age++;
                        if (m_age == STBC) enter(P_RUN);
                    end
                end
                P_RUN: begin
                    if (!m_ls) begin
                        if (m_loss < 255) m_loss++;
                        enter(P_RST);
                    end
                end
                default: begin
                    if (retry_req) begin
                        m_tries = 0;
                        enter(P_RST);
                    end
                end
            endcase
            m_ls = m_s1;
            m_s1 = lock;
        end
    end

    function automatic logic [31:0] exp_vec();
        logic [31:0] v;
        v = '0;
        v[10]  = (m_phase == P_RST);
        v[9]   = (m_phase != P_RUN);
        v[8]   = (m_phase == P_RUN);
        v[7]   = (m_phase == P_FAIL);
        v[6:3] = 4'(m_tries);
        v[2:0] = 3'(m_phase);
        return v;
    endfunction

    always @(negedge clkin) begin
        if (started) begin
            chk("cycle_outputs",
                {21'd0, pll_reset, sys_rst, ready, fail, retry_cnt, state_o},
                exp_vec());
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
            chk("cycle_loss_cnt", {24'd0, loss_cnt}, 32'(m_loss));
`endif
        end
    end

    function automatic logic sig(input int sel);
        case (sel)
            S_PR:    return pll_reset;
            S_SR:    return sys_rst;
            S_RDY:   return ready;
            default: return fail;
        endcase
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clkin);
    endtask

    task automatic wait_until(input string name, input int sel,
                              input logic val, input int bound,
                              output int n);
        n = 0;
        do begin
            @(negedge clkin);
            n++;
        end while (sig(sel) !== val && n < bound);
        chk({name, "_reached"}, {31'd0, sig(sel)}, {31'd0, val});
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_pll_reset"}, {31'd0, pll_reset}, 1);
        chk({name, "_sys_rst"}, {31'd0, sys_rst}, 1);
        chk({name, "_ready"}, {31'd0, ready}, 0);
        chk({name, "_fail"}, {31'd0, fail}, 0);
        chk({name, "_retry"}, {28'd0, retry_cnt}, 0);
        chk({name, "_state"}, {29'd0, state_o}, 0);
    endtask

    initial begin
        int n;
        int hi;
        int prev_st;
        bit saw_back;

        rst       = 1'b1;
        lock      = 1'b0;
        retry_req = 1'b0;
        wait_cyc(3);
        chk_reset_vals("por");

        // Nominal start.
        rst = 1'b0;
        wait_until("pr_fall", S_PR, 1'b0, 20, n);
        chk("pr_fall_cycles", n, 4);
        wait_cyc(6);
        lock = 1'b1;
        wait_until("nom_ready", S_RDY, 1'b1, 40, n);
        chk("nom_ready_cycles", n, 19);
        chk("nom_sys_rst", {31'd0, sys_rst}, 0);

        // Reset while in RUN, then a one-cycle glitch during STABLE.
        rst  = 1'b1;
        lock = 1'b0;
        wait_cyc(1);
        chk_reset_vals("rst_in_run");
        rst = 1'b0;
        wait_cyc(6);
        lock = 1'b1;
        wait_cyc(8);
        lock = 1'b0;
        wait_cyc(1);
        lock     = 1'b1;
        n        = 0;
        hi       = 0;
        prev_st  = -1;
        saw_back = 0;
        do begin
            @(negedge clkin);
            n++;
            if (pll_reset) hi++;
            if (prev_st == 2 && state_o == 3'd1) saw_back = 1;
            prev_st = int'(state_o);
        end while (!ready && n < 40);
        chk("glitch_ready_cycles", n, 19);
        chk("glitch_no_pll_reset", hi, 0);
        chk("glitch_back_to_wait", {31'd0, saw_back}, 1);

        // Lock loss in RUN.
        lock = 1'b0;
        wait_until("loss_sys_rst", S_SR, 1'b1, 10, n);
        chk("loss_sys_rst_cycles", n, 3);
        hi = pll_reset ? 1 : 0;
        n  = 0;
        do begin
            @(negedge clkin);
            n++;
            if (pll_reset) hi++;
        end while (pll_reset && n < 10);
        chk("loss_pll_reset_width", hi, 4);
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
        chk("loss_cnt_one", {24'd0, loss_cnt}, 1);
`endif
        lock = 1'b1;
        wait_until("relock_ready", S_RDY, 1'b1, 40, n);

        // retry_req outside FAIL does nothing.
        retry_req = 1'b1;
        wait_cyc(1);
        retry_req = 1'b0;
        chk("retry_in_run_state", {29'd0, state_o}, 3);
        chk("retry_in_run_ready", {31'd0, ready}, 1);

        // Reset while in STABLE.
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(7);
        chk("in_stable", {29'd0, state_o}, 2);
        retry_req = 1'b1;
        wait_cyc(1);
        retry_req = 1'b0;
        chk("retry_in_stable", {29'd0, state_o}, 2);
        rst = 1'b1;
        wait_cyc(1);
        chk_reset_vals("rst_in_stable");

        // Timeout exhaustion with lock held low.
        lock = 1'b0;
        rst  = 1'b0;
        n    = 0;
        hi   = 0;
        do begin
            @(negedge clkin);
            n++;
            if (pll_reset) hi++;
            if (n == 100) retry_req = 1'b1;
            if (n == 101) begin
                retry_req = 1'b0;
                chk("retry_in_wait", {28'd0, retry_cnt}, 1);
            end
        end while (!fail && n < 400);
        chk("fail_cycles", n, 204);
        chk("fail_pll_reset_samples", hi, 11);
        chk("fail_retry_cnt", {28'd0, retry_cnt}, 3);
        chk("fail_state", {29'd0, state_o}, 4);
        chk("fail_pll_reset_low", {31'd0, pll_reset}, 0);
        wait_cyc(5);
        chk("fail_holds", {31'd0, fail}, 1);
        retry_req = 1'b1;
        wait_cyc(1);
        retry_req = 1'b0;
        chk("rq_retry_cnt", {28'd0, retry_cnt}, 0);
        chk("rq_pll_reset", {31'd0, pll_reset}, 1);
        chk("rq_state", {29'd0, state_o}, 0);
        chk("rq_fail", {31'd0, fail}, 0);

        wait_cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
